// File: rtl/bnn_threshold_packer.sv
// Binarizes NUM_PES accumulated PE results against per-channel thresholds
// (with optional sign inversion) and streams them out as OUT_W-bit words.
module bnn_threshold_packer #(
  parameter int NUM_PES = 64,
  parameter int ACC_W   = 16,
  parameter int OUT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_PES*ACC_W-1:0] results_flat,
  input  logic [NUM_PES*ACC_W-1:0] thresholds_flat,
  input  logic [NUM_PES-1:0]       invert_flat,
  input  logic                     start,
  output logic                     busy,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     done,
  output logic                     overrun
);

  localparam int WORDS = NUM_PES / OUT_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  generate
    if (NUM_PES % OUT_W != 0) begin : g_bad_width
      $error("bnn_threshold_packer: NUM_PES must be a multiple of OUT_W");
    end
  endgenerate

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q, state_d;
  logic [NUM_PES-1:0] b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;

  logic [NUM_PES-1:0] new_bits;
  logic [OUT_W-1:0]   b_words [WORDS];
  logic               xfer;
  logic               at_last;
  logic               capture;
  logic [IDX_W-1:0]   idx_inc;

  // Threshold compare is unsigned; thr=0 therefore always yields 1 before inversion.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PES; gi++) begin : g_bin
      assign new_bits[gi] = (results_flat[gi*ACC_W +: ACC_W] >= thresholds_flat[gi*ACC_W +: ACC_W])
                            ^ invert_flat[gi];
    end
    for (gi = 0; gi < WORDS; gi++) begin : g_words
      assign b_words[gi] = b_q[gi*OUT_W +: OUT_W];
    end
  endgenerate

  assign xfer    = out_valid_q && out_ready;
  assign at_last = (idx_q == LAST_IDX);
  assign idx_inc = idx_q + 1'b1;
  // A new frame is accepted when idle, or when the final word leaves this cycle.
  assign capture = start && ((state_q == IDLE) || (xfer && at_last));

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = (state_q == EMIT) && xfer && at_last;
    overrun_d   = overrun_q | (start & ~capture);

    if (capture) begin
      state_d     = EMIT;
      b_d         = new_bits;
      idx_d       = '0;
      out_data_d  = new_bits[OUT_W-1:0];
      out_valid_d = 1'b1;
      out_last_d  = (WORDS == 1);
      busy_d      = 1'b1;
    end else begin
      case (state_q)
        EMIT: begin
          if (xfer) begin
            if (at_last) begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              busy_d      = 1'b0;
              out_data_d  = '0;
            end else begin
              idx_d      = idx_inc;
              out_data_d = b_words[idx_inc];
              out_last_d = (idx_inc == LAST_IDX);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      b_q         <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule
